// File: rtl/demux1to4_reg_pkg.sv
// Shared types and constants for the registered 1-to-4 demultiplexer.
package demux1to4_reg_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned LANES      = 4;
   localparam int unsigned SEL_W      = 2;

   typedef logic [SEL_W-1:0]                  sel_t;
   typedef logic [DATA_WIDTH-1:0]             data_t;
   typedef logic [LANES-1:0][DATA_WIDTH-1:0]  lane_data_t;

   // Selector encodings, identical to the 4:1 datapath mux
   localparam sel_t SEL_L0 = 2'b00;
   localparam sel_t SEL_L1 = 2'b01;
   localparam sel_t SEL_L2 = 2'b10;
   localparam sel_t SEL_L3 = 2'b11;

   // Input-side protocol checker states
   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } state_t;

   // One source offer: destination lane plus payload
   typedef struct packed {
      sel_t  sel;
      data_t data;
   } offer_t;

   // One-hot lane decode of a selector
   function automatic logic [LANES-1:0] sel_decode(input sel_t s);
      logic [LANES-1:0] oh;
      oh = '0;
      case (s)
         SEL_L0:  oh = LANES'(4'b0001);
         SEL_L1:  oh = LANES'(4'b0010);
         SEL_L2:  oh = LANES'(4'b0100);
         SEL_L3:  oh = LANES'(4'b1000);
         default: oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/demux1to4_reg_if.sv
// Source/consumer bundle of the 1-to-4 demultiplexer.
interface demux1to4_reg_if;
   import demux1to4_reg_pkg::*;

   logic              in_valid;
   logic              in_ready;
   sel_t              selector;
   data_t             data_in;
   lane_data_t        data_out;
   logic [LANES-1:0]  out_valid;
   logic [LANES-1:0]  out_ready;
   logic              proto_err;
   logic              clear_err;

   // Environment side: offers data, consumes lanes, clears errors
   modport master (
      output in_valid, selector, data_in, out_ready, clear_err,
      input  in_ready, data_out, out_valid, proto_err
   );

   // Demultiplexer side
   modport slave (
      input  in_valid, selector, data_in, out_ready, clear_err,
      output in_ready, data_out, out_valid, proto_err
   );
endinterface

// File: rtl/demux1to4_reg_lane_slot.sv
// Single-entry destination slot: one data register plus its valid bit.
module demux1to4_reg_lane_slot
   import demux1to4_reg_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  load,
   input  logic  drain,
   input  data_t data_in,
   output data_t data,
   output logic  valid,
   output logic  can_accept
);

   // Load wins over drain so a same-cycle refill keeps the slot valid; data is kept after a drain
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (load) begin
         data  <= data_in;
         valid <= 1'b1;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

   // Empty, or emptying this cycle: no bubble on refill
   assign can_accept = !valid || drain;

endmodule

// File: rtl/demux1to4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready handshake and source protocol checker.
module demux1to4_reg
   import demux1to4_reg_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   demux1to4_reg_if.slave bus
);

   logic [LANES-1:0] lane_load;
   logic [LANES-1:0] lane_drain;
   logic [LANES-1:0] lane_valid;
   logic [LANES-1:0] lane_can_accept;
   lane_data_t       lane_data;
   logic             accept;

   state_t state, state_next;
   offer_t cap, cap_next;
   offer_t live;
   logic   err, err_next;
   logic   viol;

   // Accept decision and selector decode
   assign bus.in_ready = lane_can_accept[bus.selector];
   assign accept       = bus.in_valid && bus.in_ready;
   assign lane_load    = accept ? sel_decode(bus.selector) : '0;
   assign lane_drain   = lane_valid & bus.out_ready;
   assign live         = '{sel: bus.selector, data: bus.data_in};

   // Four independent destination slots
   for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
      demux1to4_reg_lane_slot u_slot (
         .clk        (clk),
         .reset      (reset),
         .load       (lane_load[i]),
         .drain      (lane_drain[i]),
         .data_in    (bus.data_in),
         .data       (lane_data[i]),
         .valid      (lane_valid[i]),
         .can_accept (lane_can_accept[i])
      );
   end

   assign bus.data_out  = lane_data;
   assign bus.out_valid = lane_valid;
   assign bus.proto_err = err;

   // Checker state, captured offer and sticky error flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cap   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_next;
         cap   <= cap_next;
         err   <= err_next;
      end
   end

   // A stalled offer must be held unchanged until accepted; dropping or altering it is a violation
   always_comb begin
      state_next = state;
      cap_next   = cap;
      viol       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_valid && !bus.in_ready) begin
               state_next = STALL;
               cap_next   = live;
            end
         end
         STALL: begin
            if (!bus.in_valid) begin
               state_next = IDLE;
               viol       = 1'b1;
            end else begin
               if (live != cap) viol = 1'b1;
               if (bus.in_ready) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      err_next = bus.clear_err ? 1'b0 : (err || viol);
   end

endmodule
